hwpe_vfpu_ctrl_fsm: RTL and testbench

HWPE_VFPU_CTRL_FSM -- requirements
Module: hwpe_vfpu_ctrl_fsm

---
 rtl/hwpe_vfpu_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_hwpe_vfpu_ctrl_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_vfpu_ctrl_fsm.sv
// hwpe_vfpu_ctrl_fsm: job sequencer for the vector FPU engine.
// Issues three stream-start requests, counts result words and reports done/err/flags.
module hwpe_vfpu_ctrl_fsm #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_a_i,
    input  logic [31:0]          base_addr_b_i,
    input  logic [31:0]          base_addr_res_i,
    input  logic [31:0]          trans_size_i,
    input  logic [31:0]          op_rm_i,
    output logic                 req_a_valid_o,
    output logic                 req_b_valid_o,
    output logic                 req_res_valid_o,
    input  logic                 req_a_ready_i,
    input  logic                 req_b_ready_i,
    input  logic                 req_res_ready_i,
    output logic [31:0]          req_a_addr_o,
    output logic [31:0]          req_b_addr_o,
    output logic [31:0]          req_res_addr_o,
    output logic [CNT_WIDTH-1:0] req_len_o,
    input  logic                 res_hs_i,
    input  logic [5:0]           flags_i,
    output logic [3:0]           ctrl_vfpu_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [5:0]           flags_o
);
    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_e;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;
    state_e               state_q;
    logic [31:0]          addr_a_q, addr_b_q, addr_res_q;
    logic [CNT_WIDTH-1:0] len_q, cnt_q;
    logic [3:0]           ctrl_q;
    logic [5:0]           flags_q;
    logic                 err_q, va_q, vb_q, vr_q;
    logic                 va_d, vb_d, vr_d;
    logic [CNT_WIDTH-1:0] size_d;
    logic                 bad_op_d;
    logic                 unused_bits;
    assign size_d      = trans_size_i[CNT_WIDTH-1:0];
    assign bad_op_d    = op_rm_i[1:0] == 2'b11;
    assign unused_bits = ^{trans_size_i[31:CNT_WIDTH], op_rm_i[31:4]};
    assign va_d = va_q & ~req_a_ready_i;
    assign vb_d = vb_q & ~req_b_ready_i;
    assign vr_d = vr_q & ~req_res_ready_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_res_q <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            va_q       <= 1'b0;
            vb_q       <= 1'b0;
            vr_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    addr_a_q   <= base_addr_a_i;
                    addr_b_q   <= base_addr_b_i;
                    addr_res_q <= base_addr_res_i;
                    len_q      <= size_d;
                    ctrl_q     <= {op_rm_i[1:0], op_rm_i[3:2]};
                    flags_q    <= '0;
                    cnt_q      <= '0;
                    err_q      <= bad_op_d;
                    if (size_d == '0 || bad_op_d) state_q <= DONE;
                    else begin
                        state_q <= REQ;
                        va_q    <= 1'b1;
                        vb_q    <= 1'b1;
                        vr_q    <= 1'b1;
                    end
                end
                REQ: begin
                    va_q <= va_d;
                    vb_q <= vb_d;
                    vr_q <= vr_d;
                    // early sink handshakes count toward the job before RUN
                    if (res_hs_i) begin
                        cnt_q   <= cnt_q + ONE;
                        flags_q <= flags_q | flags_i;
                    end
                    if (!(va_d | vb_d | vr_d)) state_q <= RUN;
                end
                RUN: if (res_hs_i) begin
                    cnt_q   <= cnt_q + ONE;
                    flags_q <= flags_q | flags_i;
                    if (cnt_q == len_q - ONE) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_a_valid_o   = va_q;
    assign req_b_valid_o   = vb_q;
    assign req_res_valid_o = vr_q;
    assign req_a_addr_o    = addr_a_q;
    assign req_b_addr_o    = addr_b_q;
    assign req_res_addr_o  = addr_res_q;
    assign req_len_o       = len_q;
    assign ctrl_vfpu_o     = ctrl_q;
    assign flags_o         = flags_q;
    assign busy_o          = state_q != IDLE;
    assign done_o          = state_q == DONE;
    assign err_o           = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_hwpe_vfpu_ctrl_fsm.sv
// tb_hwpe_vfpu_ctrl_fsm: randomized scoreboard bench for the VFPU control FSM.
// The driver predicts request vectors and job outcomes; a negedge monitor pops and compares.
module tb_hwpe_vfpu_ctrl_fsm;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_i, start_i, ra, rb, rr, hs;
    logic [31:0] addr_a, addr_b, addr_r, trans_size, op_rm;
    logic [5:0] flags_in;
    logic va, vb, vr, busy, done, err;
    logic [31:0] oa, ob, orr;
    logic [W-1:0] len;
    logic [3:0] ctrl;
    logic [5:0] flags_out;
    int checks = 0, failures = 0, cyc = 0, exp_at = 0;
    typedef struct {logic [2:0] v; logic [31:0] a, b, r; logic [W-1:0] len;} req_t;
    typedef struct {logic [5:0] flags; logic err; logic [3:0] ctrl;} done_t;
    req_t req_q[$];
    done_t done_q[$];
    req_t re;
    done_t de;

    hwpe_vfpu_ctrl_fsm #(.CNT_WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .base_addr_a_i(addr_a), .base_addr_b_i(addr_b), .base_addr_res_i(addr_r),
        .trans_size_i(trans_size), .op_rm_i(op_rm),
        .req_a_valid_o(va), .req_b_valid_o(vb), .req_res_valid_o(vr),
        .req_a_ready_i(ra), .req_b_ready_i(rb), .req_res_ready_i(rr),
        .req_a_addr_o(oa), .req_b_addr_o(ob), .req_res_addr_o(orr), .req_len_o(len),
        .res_hs_i(hs), .flags_i(flags_in), .ctrl_vfpu_o(ctrl),
        .busy_o(busy), .done_o(done), .err_o(err), .flags_o(flags_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (va | vb | vr) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%b expected=000", {vr, vb, va});
            end else begin
                re = req_q.pop_front();
                chk("valids", {29'b0, vr, vb, va}, {29'b0, re.v});
                chk("addr_a", oa, re.a);
                chk("addr_b", ob, re.b);
                chk("addr_res", orr, re.r);
                chk("req_len", {28'b0, len}, {28'b0, re.len});
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, exp_at);
                chk("done_flags", {26'b0, flags_out}, {26'b0, de.flags});
                chk("done_err", {31'b0, err}, {31'b0, de.err});
                chk("done_ctrl", {28'b0, ctrl}, {28'b0, de.ctrl});
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, {31'b0, busy}, 0);
    endtask

    // mode: 0 random readies, 1 all ready at once, 2 a/b/res accepted in REQ cycles 1/3/5
    task automatic job(input int size, input int op, input int rm, input int mode,
                       input bit early, input bit spur, input bit fixed);
        logic [5:0] fv[$];
        logic [5:0] acc_f;
        logic [2:0] acc, rdy;
        logic [31:0] t;
        logic [3:0] c;
        bit deg;
        int k;
        wait_idle("idle_before_start");
        deg = (size == 0) || (op == 3);
        acc_f = '0;
        if (!deg)
            for (int i = 0; i < size; i++) begin
                t = $urandom;
                fv.push_back(fixed ? (i == 0 ? 6'b000100 : i == 1 ? 6'b100000 : 6'b0) : t[5:0]);
                acc_f |= fv[i];
            end
        c = {op[1:0], rm[1:0]};
        addr_a = $urandom;
        addr_b = $urandom;
        addr_r = $urandom;
        t = $urandom;
        trans_size = {t[31:W], size[W-1:0]};
        t = $urandom;
        op_rm = {t[31:4], rm[1:0], op[1:0]};
        done_q.push_back('{flags: deg ? 6'b0 : acc_f, err: op == 3, ctrl: c});
        start_i = 1'b1;
        if (deg) exp_at = cyc + 1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("flags_cleared", {26'b0, flags_out}, 0);
        chk("busy_after_start", {31'b0, busy}, 1);
        if (!deg) begin
            acc = '0;
            k = 1;
            while (acc != 3'b111) begin
                req_q.push_back('{v: ~acc, a: addr_a, b: addr_b, r: addr_r, len: size[W-1:0]});
                rdy = mode == 1 ? 3'b111 :
                      mode == 2 ? {k == 5, k == 3, k == 1} :
                      k > 6 ? 3'b111 : 3'($urandom_range(7, 0));
                {rr, rb, ra} = rdy;
                hs = early && k == 1;
                t = $urandom;
                flags_in = hs ? fv.pop_front() : t[5:0];
                @(posedge clk);
                #1;
                acc |= rdy;
                k++;
            end
            {rr, rb, ra} = 3'b000;
            hs = 1'b0;
            if (spur) begin
                start_i = 1'b1;
                trans_size = 32'h1;
                @(posedge clk);
                #1;
                start_i = 1'b0;
                chk("len_after_spurious_start", {28'b0, len}, size);
            end
            while (fv.size() > 0) begin
                repeat ($urandom_range(2, 0)) begin
                    t = $urandom;
                    flags_in = t[5:0];
                    @(posedge clk);
                    #1;
                end
                hs = 1'b1;
                flags_in = fv.pop_front();
                if (fv.size() == 0) exp_at = cyc + 1;
                @(posedge clk);
                #1;
                hs = 1'b0;
            end
        end
        wait_idle("idle_after_job");
        chk("ctrl_hold", {28'b0, ctrl}, {28'b0, c});
        chk("flags_hold", {26'b0, flags_out}, {26'b0, deg ? 6'b0 : acc_f});
    endtask

    task automatic reset_mid_run();
        wait_idle("idle_before_reset_job");
        addr_a = 32'h100;
        addr_b = 32'h200;
        addr_r = 32'h300;
        trans_size = 32'd5;
        op_rm = 32'h4;
        start_i = 1'b1;
        req_q.push_back('{v: 3'b111, a: 32'h100, b: 32'h200, r: 32'h300, len: 4'd5});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        {rr, rb, ra} = 3'b111;
        @(posedge clk);
        #1;
        {rr, rb, ra} = 3'b000;
        hs = 1'b1;
        flags_in = 6'b010001;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        hs = 1'b0;
        chk("flags_before_reset", {26'b0, flags_out}, 32'h11);
        rst_i = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_valids", {29'b0, vr, vb, va}, 0);
        chk("rst_done_err", {30'b0, done, err}, 0);
        chk("rst_flags", {26'b0, flags_out}, 0);
        chk("rst_ctrl", {28'b0, ctrl}, 0);
        chk("rst_addr", oa | ob | orr, 0);
        chk("rst_len", {28'b0, len}, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        hs = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hs = 1'b0;
        chk("no_done_after_reset", {31'b0, busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        {start_i, ra, rb, rr, hs} = '0;
        {addr_a, addr_b, addr_r, trans_size, op_rm} = '0;
        flags_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_valids", {29'b0, vr, vb, va}, 0);
        chk("reset_done_err", {30'b0, done, err}, 0);
        chk("reset_ctrl_flags", {22'b0, ctrl, flags_out}, 0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        job(4, 0, 1, 1, 0, 0, 0);
        chk("ctrl_add_nearest", {28'b0, ctrl}, 32'h1);
        job(6, 1, 2, 2, 0, 0, 0);
        job(0, 0, 0, 1, 0, 0, 0);
        job(5, 3, 0, 1, 0, 0, 0);
        job(3, 2, 3, 1, 0, 0, 1);
        job(2, 1, 0, 1, 0, 0, 0);
        job(15, 0, 2, 0, 0, 0, 0);
        job(1, 2, 1, 0, 0, 0, 0);
        job(5, 1, 1, 0, 1, 0, 0);
        job(4, 0, 0, 0, 0, 1, 0);
        reset_mid_run();
        for (int n = 0; n < 30; n++) begin
            automatic int sz = $urandom_range(15, 0);
            automatic int op = $urandom_range(5, 0) == 0 ? 3 : $urandom_range(2, 0);
            job(sz, op, $urandom_range(3, 0), 0, sz >= 2 && $urandom_range(1, 0) == 1,
                $urandom_range(3, 0) == 0, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_empty", req_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
